// File: rtl/corebus_sram_responder.sv
// corebus_sram_responder: CoreBus responder servicing READ/WRITE/WRITE_NP from a register-array memory.
// Define CORBUS_RSP_RANDOM_STALL_EN to add LFSR-driven accept/response stalls.
module corebus_sram_responder #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mcmd_valid,
    output logic              o_scmd_accept,
    input  logic [1:0]        i_mcmd,
    input  logic [ID_W-1:0]   i_mid,
    input  logic [ADDR_W-1:0] i_maddr,
    input  logic [LEN_W-1:0]  i_mlength,
    input  logic              i_mdata_valid,
    output logic              o_sdata_accept,
    input  logic [DATA_W-1:0] i_mdata,
    input  logic [BE_W-1:0]   i_mdata_byteen,
    input  logic              i_mdata_last,
    output logic              o_sresp_valid,
    input  logic              i_mresp_accept,
    output logic              o_sresp,
    output logic [ID_W-1:0]   o_sid,
    output logic              o_serror,
    output logic [DATA_W-1:0] o_sdata,
    output logic              o_sresp_last
);
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = LEN_W + 1;
    typedef enum logic [1:0] {IDLE, WDATA, WRRESP, RDRESP} state_t;
    state_t state, state_nx;
    logic [1:0]        cmd_q;
    logic [ID_W-1:0]   id_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  n_q, beat_q, n_in;
    logic              err_q, held_q, stall, rsp_st, last_beat, addr_err;
    logic              cmd_hs, dat_hs, rsp_hs;
    logic [DATA_W-1:0] mem [DEPTH];
`ifdef CORBUS_RSP_RANDOM_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = lfsr[1:0] == 2'b00;
`else
    assign stall = 1'b0;
`endif
    assign n_in      = (i_mlength == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, i_mlength};
    assign addr_err  = (i_maddr >> (OFF_W + IDX_W)) != '0;
    assign last_beat = CNT_W'(beat_q + 1'b1) == n_q;
    assign rsp_st    = state == WRRESP || state == RDRESP;
    // a beat already on the bus stays valid; stalls only delay starting one
    assign o_sresp_valid  = rsp_st && (held_q || !stall);
    assign o_scmd_accept  = state == IDLE && !stall;
    assign o_sdata_accept = state == WDATA && !stall;
    assign o_sresp        = state == RDRESP;
    assign o_sid          = rsp_st ? id_q : '0;
    assign o_serror       = rsp_st && err_q;
    assign o_sdata        = (state == RDRESP && !err_q) ? mem[idx_q] : '0;
    assign o_sresp_last   = state == WRRESP || (state == RDRESP && last_beat);
    assign cmd_hs = i_mcmd_valid && o_scmd_accept;
    assign dat_hs = i_mdata_valid && o_sdata_accept;
    assign rsp_hs = o_sresp_valid && i_mresp_accept;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_hs) state_nx = i_mcmd == 2'd0 ? RDRESP : i_mcmd == 2'd3 ? WRRESP : WDATA;
            WDATA:   if (dat_hs && (i_mdata_last || last_beat)) state_nx = cmd_q == 2'd2 ? WRRESP : IDLE;
            WRRESP:  if (rsp_hs) state_nx = IDLE;
            RDRESP:  if (rsp_hs && last_beat) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            held_q <= 1'b0;
            cmd_q  <= '0;
            id_q   <= '0;
            idx_q  <= '0;
            n_q    <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            held_q <= o_sresp_valid && !i_mresp_accept;
            if (cmd_hs) begin
                cmd_q  <= i_mcmd;
                id_q   <= i_mid;
                idx_q  <= i_maddr[OFF_W +: IDX_W];
                n_q    <= n_in;
                beat_q <= '0;
                err_q  <= addr_err || i_mcmd == 2'd3;
            end else if (dat_hs || rsp_hs) begin
                idx_q  <= idx_q + 1'b1;
                beat_q <= beat_q + 1'b1;
                // a misplaced or missing last flag poisons the write response
                err_q  <= err_q || (dat_hs && (i_mdata_last != last_beat));
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (dat_hs && !err_q)
            for (int b = 0; b < BE_W; b++)
                if (i_mdata_byteen[b]) mem[idx_q][b*8 +: 8] <= i_mdata[b*8 +: 8];
    end
endmodule
